// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads the PC, fetches the word over a req/ack memory port,
// hands it to decode with valid/ready, then writes the next PC back to the PC register.
module instr_fetch #(
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        Clock_in,
    input  logic        Signal_reset,
    input  logic [31:0] Pc_in,
    output logic [31:0] Pc_next,
    output logic        Pc_write,
    output logic        Mem_req,
    output logic [31:0] Mem_addr,
    input  logic        Mem_ack,
    input  logic [31:0] Mem_rdata,
    output logic [31:0] Instr_out,
    output logic [31:0] Instr_pc,
    output logic        Instr_valid,
    input  logic        Instr_ready,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    output logic        Fetch_error
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [31:0]      PC_STEP_C  = 32'(PC_STEP);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        HOLD   = 3'd2,
        UPDATE = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic [31:0]      pc_next_s, instr_out_s, instr_pc_s;
    logic             pc_write_s, instr_valid_s, fetch_error_s;
    logic [CNT_W-1:0] wait_inc_s;

    // Request path is combinational so the address tracks Pc_in within the FETCH cycle
    always_comb begin
        Mem_req  = (state_r == FETCH);
        Mem_addr = (state_r == FETCH) ? Pc_in : 32'h0000_0000;
    end

    // Next-state and next-output decode
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        pc_next_s     = Pc_next;
        pc_write_s    = 1'b0;
        instr_out_s   = Instr_out;
        instr_pc_s    = Instr_pc;
        instr_valid_s = Instr_valid;
        fetch_error_s = Fetch_error;
        wait_inc_s    = wait_cnt_r + CNT_ONE_C;
        case (state_r)
            IDLE: begin
                state_s = FETCH;
            end
            FETCH: begin
                if (Mem_ack) begin
                    instr_out_s   = Mem_rdata;
                    instr_pc_s    = Pc_in;
                    instr_valid_s = 1'b1;
                    wait_cnt_s    = '0;
                    state_s       = HOLD;
                end else if (wait_inc_s == MAX_WAIT_C) begin
                    // Timeout is terminal until reset
                    wait_cnt_s    = wait_inc_s;
                    fetch_error_s = 1'b1;
                    instr_valid_s = 1'b0;
                    state_s       = ERROR;
                end else begin
                    wait_cnt_s = wait_inc_s;
                end
            end
            HOLD: begin
                if (Instr_ready) begin
                    instr_valid_s = 1'b0;
                    pc_write_s    = 1'b1;
                    pc_next_s     = Branch_taken ? Branch_target : (Instr_pc + PC_STEP_C);
                    state_s       = UPDATE;
                end else begin
                    state_s = HOLD;
                end
            end
            UPDATE: begin
                state_s = FETCH;
            end
            ERROR: begin
                state_s       = ERROR;
                fetch_error_s = 1'b1;
                instr_valid_s = 1'b0;
            end
            default: begin
                state_s       = ERROR;
                fetch_error_s = 1'b1;
                instr_valid_s = 1'b0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge Clock_in or posedge Signal_reset) begin
        if (Signal_reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Registered outputs
    always_ff @(posedge Clock_in or posedge Signal_reset) begin
        if (Signal_reset) begin
            Pc_next     <= 32'h0000_0000;
            Pc_write    <= 1'b0;
            Instr_out   <= 32'h0000_0000;
            Instr_pc    <= 32'h0000_0000;
            Instr_valid <= 1'b0;
            Fetch_error <= 1'b0;
        end else begin
            Pc_next     <= pc_next_s;
            Pc_write    <= pc_write_s;
            Instr_out   <= instr_out_s;
            Instr_pc    <= instr_pc_s;
            Instr_valid <= instr_valid_s;
            Fetch_error <= fetch_error_s;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: fetch, backpressure, branch, wrap,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fetch_error;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.PC_STEP(4), .MAX_WAIT(15)) dut (
        .Clock_in     (clk),
        .Signal_reset (rst),
        .Pc_in        (pc_in),
        .Pc_next      (pc_next),
        .Pc_write     (pc_write),
        .Mem_req      (mem_req),
        .Mem_addr     (mem_addr),
        .Mem_ack      (mem_ack),
        .Mem_rdata    (mem_rdata),
        .Instr_out    (instr_out),
        .Instr_pc     (instr_pc),
        .Instr_valid  (instr_valid),
        .Instr_ready  (instr_ready),
        .Branch_taken (branch_taken),
        .Branch_target(branch_target),
        .Fetch_error  (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; pc_in = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        @(negedge clk); @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_pc_write", {31'd0, pc_write}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_error", {31'd0, fetch_error}, 32'd0);
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);

        // Basic fetch: ack on the third FETCH cycle
        rst = 1'b0; instr_ready = 1'b1;
        tick();
        check("fetch1_req", {31'd0, mem_req}, 32'd1);
        check("fetch1_addr", mem_addr, 32'h0);
        tick();
        tick();
        check("fetch3_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
        tick();
        mem_ack = 1'b0;
        check("basic_valid", {31'd0, instr_valid}, 32'd1);
        check("basic_out", instr_out, 32'h8C01_0004);
        check("basic_pc", instr_pc, 32'h0);
        check("basic_hold_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("basic_pc_write", {31'd0, pc_write}, 32'd1);
        check("basic_pc_next", pc_next, 32'h4);
        check("basic_valid_drop", {31'd0, instr_valid}, 32'd0);
        tick();
        check("basic_pc_write_end", {31'd0, pc_write}, 32'd0);
        check("basic_pc_next_held", pc_next, 32'h4);
        pc_in = 32'h4;
        #1;
        check("fetch_addr4", mem_addr, 32'h4);

        // Backpressure: five cycles with decode not ready
        instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_out", instr_out, 32'h1234_5678);
            check("bp_req", {31'd0, mem_req}, 32'd0);
            check("bp_pc_write", {31'd0, pc_write}, 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        check("bp_pc_write_pulse", {31'd0, pc_write}, 32'd1);
        check("bp_pc_next", pc_next, 32'h8);
        tick();
        check("bp_pc_write_single", {31'd0, pc_write}, 32'd0);

        // Branch taken at the handshake edge
        pc_in = 32'h10; mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
        tick();
        mem_ack = 1'b0;
        check("br_instr_pc", instr_pc, 32'h10);
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        check("br_taken_next", pc_next, 32'h40);
        tick();
        // Branch_taken high during FETCH but low at handshake: sequential
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_0002;
        tick();
        mem_ack = 1'b0; branch_taken = 1'b0;
        tick();
        check("br_not_taken_next", pc_next, 32'h14);
        tick();

        // Wrap-around of the sequential PC
        pc_in = 32'hFFFF_FFFC; mem_ack = 1'b1; mem_rdata = 32'hBBBB_0003;
        tick();
        mem_ack = 1'b0;
        tick();
        check("wrap_pc_write", {31'd0, pc_write}, 32'd1);
        check("wrap_pc_next", pc_next, 32'h0);

        // Async reset between edges while in UPDATE
        #2 rst = 1'b1;
        #1;
        check("arst_upd_pc_write", {31'd0, pc_write}, 32'd0);
        check("arst_upd_pc_next", pc_next, 32'h0);
        check("arst_upd_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0; pc_in = 32'h20;
        tick();
        check("arst_restart_req", {31'd0, mem_req}, 32'd1);
        check("arst_restart_addr", mem_addr, 32'h20);

        // Async reset between edges while in FETCH
        #2 rst = 1'b1;
        #1;
        check("arst_fetch_req", {31'd0, mem_req}, 32'd0);
        check("arst_fetch_addr", mem_addr, 32'h0);
        check("arst_fetch_pc_write", {31'd0, pc_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0; instr_ready = 1'b0;
        tick();

        // Timeout: 14 missing acks keep fetching, the 15th enters ERROR
        for (int i = 0; i < 14; i++) tick();
        check("to_pre_req", {31'd0, mem_req}, 32'd1);
        check("to_pre_error", {31'd0, fetch_error}, 32'd0);
        tick();
        check("to_error", {31'd0, fetch_error}, 32'd1);
        check("to_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("to_sticky", {31'd0, fetch_error}, 32'd1);
        check("to_ack_ignored_valid", {31'd0, instr_valid}, 32'd0);
        check("to_ack_ignored_req", {31'd0, mem_req}, 32'd0);
        check("to_pc_write", {31'd0, pc_write}, 32'd0);
        mem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("to_reset_clear", {31'd0, fetch_error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("to_idle_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("to_restart_req", {31'd0, mem_req}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
